gd_audio_mixer: RTL and testbench

//  Parametrised NCH-source stereo audio mixer and 1-bit DAC back end for the sound subsystem.

---
 rtl/gd_audio_mixer.sv | 180 ++++++++++++++++++
 tb/tb_gd_audio_mixer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gd_audio_mixer.sv
// NCH-source stereo mixer: per-channel Q1.7 gains, time-multiplexed multiply-accumulate,
// per-frame decimation with saturation, and first-order sigma-delta DAC outputs.
module gd_audio_mixer #(
    parameter int         NCH        = 2,
    parameter int         IN_W       = 18,
    parameter int         OUT_W      = 13,
    parameter int         DECIM_LOG2 = 6,
    parameter int         OUT_SHIFT  = 5,
    parameter logic [9:0] BASE_ADDR  = 10'h150
) (
    input  logic                vga_clk,
    input  logic                reset,
    input  logic                mem_wr,
    input  logic [14:0]         mem_w_addr,
    input  logic [7:0]          mem_data_wr,
    input  logic                mem_rd,
    input  logic [14:0]         mem_r_addr,
    output logic [7:0]          mem_data_rd,
    input  logic [NCH*IN_W-1:0] src_data,
    input  logic [15:0]         sample_l,
    input  logic [15:0]         sample_r,
    output logic [17:0]         soundcounter,
    output logic                frame_strobe,
    output logic                AUDIOL,
    output logic                AUDIOR
);
    localparam int ACC_W  = IN_W + 2 + $clog2(NCH + 1);
    localparam int PROD_W = IN_W + 9;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (OUT_W - 1)));
    localparam logic [OUT_W-1:0]        DAC_MID = {1'b1, {(OUT_W - 1){1'b0}}};

    logic [7:0]               r_gainL [NCH];
    logic [7:0]               r_gainR [NCH];
    logic [1:0]               r_ctrl;
    logic                     r_clipL;
    logic                     r_clipR;
    logic signed [ACC_W-1:0]  r_accL;
    logic signed [ACC_W-1:0]  r_accR;
    logic signed [OUT_W-1:0]  r_lvalue;
    logic signed [OUT_W-1:0]  r_rvalue;
    logic [OUT_W:0]           r_dacL;
    logic [OUT_W:0]           r_dacR;

    logic [DECIM_LOG2-1:0]    w_ph;
    logic                     w_slot;
    logic                     w_frameEnd;
    logic signed [IN_W-1:0]   w_src;
    logic signed [8:0]        w_gainL;
    logic signed [8:0]        w_gainR;
    logic signed [PROD_W-1:0] w_prodL;
    logic signed [PROD_W-1:0] w_prodR;
    logic signed [ACC_W-1:0]  w_addL;
    logic signed [ACC_W-1:0]  w_addR;
    logic signed [ACC_W-1:0]  w_shL;
    logic signed [ACC_W-1:0]  w_shR;
    logic [OUT_W:0]           w_satL;
    logic [OUT_W:0]           w_satR;
    logic                     w_wrHit;
    logic                     w_rdHit;
    logic                     w_clrStatus;
    logic [4:0]               w_wOff;
    logic [4:0]               w_rOff;
    logic [7:0]               w_rdData;
    logic [OUT_W-1:0]         w_uL;
    logic [OUT_W-1:0]         w_uR;

    // Returns {clip, clamped value}.
    function automatic logic [OUT_W:0] fnSat(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) return {1'b1, SAT_MAX[OUT_W-1:0]};
        else if (v < SAT_MIN) return {1'b1, SAT_MIN[OUT_W-1:0]};
        else return {1'b0, v[OUT_W-1:0]};
    endfunction

    assign w_ph         = soundcounter[DECIM_LOG2-1:0];
    assign w_frameEnd   = &w_ph;
    assign frame_strobe = w_frameEnd;

    always_comb begin
        w_slot  = 1'b0;
        w_src   = '0;
        w_gainL = '0;
        w_gainR = '0;
        for (int c = 0; c < NCH; c++) begin
            if (w_ph == DECIM_LOG2'(c)) begin
                w_slot  = 1'b1;
                w_src   = src_data[c*IN_W +: IN_W];
                w_gainL = {1'b0, r_gainL[c]};
                w_gainR = {1'b0, r_gainR[c]};
            end
        end
    end

    assign w_prodL = PROD_W'(w_src) * PROD_W'(w_gainL);
    assign w_prodR = PROD_W'(w_src) * PROD_W'(w_gainR);
    assign w_addL  = ACC_W'(w_prodL >>> 7);
    assign w_addR  = ACC_W'(w_prodR >>> 7);
    assign w_shL   = r_accL >>> OUT_SHIFT;
    assign w_shR   = r_accR >>> OUT_SHIFT;
    assign w_satL  = fnSat(w_shL);
    assign w_satR  = fnSat(w_shR);

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            soundcounter <= '0;
            r_accL       <= '0;
            r_accR       <= '0;
            r_lvalue     <= '0;
            r_rvalue     <= '0;
        end else begin
            soundcounter <= soundcounter + 18'd1;
            if (w_frameEnd) begin
                r_lvalue <= w_satL[OUT_W-1:0];
                r_rvalue <= w_satR[OUT_W-1:0];
                r_accL   <= r_ctrl[1] ? ACC_W'($signed(sample_l)) : '0;
                r_accR   <= r_ctrl[1] ? ACC_W'($signed(sample_r)) : '0;
            end else if (w_slot) begin
                r_accL <= r_accL + w_addL;
                r_accR <= r_accR + w_addR;
            end
        end
    end

    assign w_wrHit     = mem_wr && (mem_w_addr[14:5] == BASE_ADDR);
    assign w_rdHit     = mem_rd && (mem_r_addr[14:5] == BASE_ADDR);
    assign w_wOff      = mem_w_addr[4:0];
    assign w_rOff      = mem_r_addr[4:0];
    assign w_clrStatus = w_wrHit && (w_wOff == 5'h1E);

    always_comb begin
        w_rdData = 8'h00;
        if (w_rdHit) begin
            for (int c = 0; c < NCH; c++) begin
                if (w_rOff == 5'(2 * c))     w_rdData = r_gainL[c];
                if (w_rOff == 5'(2 * c + 1)) w_rdData = r_gainR[c];
            end
            if (w_rOff == 5'h1E) w_rdData = {6'd0, r_clipR, r_clipL};
            if (w_rOff == 5'h1F) w_rdData = {6'd0, r_ctrl};
        end
    end

    // A clip on the same edge as a clearing write leaves the flag set.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                r_gainL[c] <= 8'h80;
                r_gainR[c] <= 8'h80;
            end
            r_ctrl      <= 2'b10;
            r_clipL     <= 1'b0;
            r_clipR     <= 1'b0;
            mem_data_rd <= 8'h00;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (w_wrHit && (w_wOff == 5'(2 * c)))     r_gainL[c] <= mem_data_wr;
                if (w_wrHit && (w_wOff == 5'(2 * c + 1))) r_gainR[c] <= mem_data_wr;
            end
            if (w_wrHit && (w_wOff == 5'h1F)) r_ctrl <= mem_data_wr[1:0];
            r_clipL     <= (r_clipL && !w_clrStatus) || (w_frameEnd && w_satL[OUT_W]);
            r_clipR     <= (r_clipR && !w_clrStatus) || (w_frameEnd && w_satR[OUT_W]);
            mem_data_rd <= w_rdData;
        end
    end

    assign w_uL = r_ctrl[0] ? DAC_MID : (r_lvalue ^ DAC_MID);
    assign w_uR = r_ctrl[0] ? DAC_MID : (r_rvalue ^ DAC_MID);

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_dacL <= '0;
            r_dacR <= '0;
        end else begin
            r_dacL <= {1'b0, r_dacL[OUT_W-1:0]} + {1'b0, w_uL};
            r_dacR <= {1'b0, r_dacR[OUT_W-1:0]} + {1'b0, w_uR};
        end
    end

    assign AUDIOL = r_dacL[OUT_W];
    assign AUDIOR = r_dacR[OUT_W];
endmodule

// File: tb/tb_gd_audio_mixer.sv
// Testbench for gd_audio_mixer: register map, frame timing, DAC duty and reset behaviour,
// plus randomized frames compared against a plain arithmetic mixing model.
module tb_gd_audio_mixer;
    localparam int         NCH        = 2;
    localparam int         IN_W       = 18;
    localparam int         OUT_W      = 13;
    localparam int         DECIM_LOG2 = 6;
    localparam int         OUT_SHIFT  = 0;
    localparam logic [9:0] BASE_ADDR  = 10'h150;
    localparam int         DAC_WINDOW = 2 ** OUT_W;
    localparam int         OUT_MAX    = (2 ** (OUT_W - 1)) - 1;
    localparam int         OUT_MIN    = -(2 ** (OUT_W - 1));

    logic                vga_clk = 1'b0;
    logic                reset;
    logic                mem_wr;
    logic [14:0]         mem_w_addr;
    logic [7:0]          mem_data_wr;
    logic                mem_rd;
    logic [14:0]         mem_r_addr;
    logic [7:0]          mem_data_rd;
    logic [NCH*IN_W-1:0] src_data;
    logic [15:0]         sample_l;
    logic [15:0]         sample_r;
    logic [17:0]         soundcounter;
    logic                frame_strobe;
    logic                AUDIOL;
    logic                AUDIOR;

    gd_audio_mixer #(
        .NCH(NCH), .IN_W(IN_W), .OUT_W(OUT_W), .DECIM_LOG2(DECIM_LOG2),
        .OUT_SHIFT(OUT_SHIFT), .BASE_ADDR(BASE_ADDR)
    ) dut (
        .vga_clk(vga_clk), .reset(reset),
        .mem_wr(mem_wr), .mem_w_addr(mem_w_addr), .mem_data_wr(mem_data_wr),
        .mem_rd(mem_rd), .mem_r_addr(mem_r_addr), .mem_data_rd(mem_data_rd),
        .src_data(src_data), .sample_l(sample_l), .sample_r(sample_r),
        .soundcounter(soundcounter), .frame_strobe(frame_strobe),
        .AUDIOL(AUDIOL), .AUDIOR(AUDIOR)
    );

    always #5 vga_clk = ~vga_clk;

    int checkCount = 0;
    int passCount  = 0;
    int srcV   [NCH];
    int gainLV [NCH];
    int gainRV [NCH];
    int unityV [NCH];
    int sampLV;
    int sampRV;
    bit extEnV;
    bit muteV;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checkCount++;
        if (observed == expected) passCount++;
        else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    endtask

    // Mixing model: sum of floor(src*gain/128) plus the external sample, then shift.
    function automatic int mixModel(input int src[NCH], input int gain[NCH], input int ext);
        longint acc = longint'(ext);
        for (int c = 0; c < NCH; c++) acc += (longint'(src[c]) * longint'(gain[c])) >>> 7;
        return int'(acc >>> OUT_SHIFT);
    endfunction

    function automatic int clampModel(input int v);
        if (v > OUT_MAX) return OUT_MAX;
        if (v < OUT_MIN) return OUT_MIN;
        return v;
    endfunction

    task automatic memWrite(input logic [4:0] off, input logic [7:0] data);
        mem_w_addr  = {BASE_ADDR, off};
        mem_data_wr = data;
        mem_wr      = 1'b1;
        @(negedge vga_clk);
        mem_wr = 1'b0;
    endtask

    task automatic memRead(input logic [9:0] base, input logic [4:0] off, output logic [7:0] data);
        mem_r_addr = {base, off};
        mem_rd     = 1'b1;
        @(negedge vga_clk);
        data   = mem_data_rd;
        mem_rd = 1'b0;
    endtask

    task automatic waitPh(input int target);
        for (int i = 0; i < 200; i++) begin
            @(negedge vga_clk);
            if (int'(soundcounter[DECIM_LOG2-1:0]) == target) return;
        end
        checkOutput("waitPh timeout", longint'(soundcounter[DECIM_LOG2-1:0]), longint'(target));
    endtask

    task automatic waitStrobe();
        for (int i = 0; i < 200; i++) begin
            @(negedge vga_clk);
            if (frame_strobe) return;
        end
        checkOutput("frame_strobe timeout", longint'(frame_strobe), 1);
    endtask

    task automatic driveSources();
        for (int c = 0; c < NCH; c++) src_data[c*IN_W +: IN_W] = IN_W'(srcV[c]);
        sample_l = 16'(sampLV);
        sample_r = 16'(sampRV);
    endtask

    task automatic applyStimulus();
        driveSources();
        for (int c = 0; c < NCH; c++) begin
            memWrite(5'(2 * c), 8'(gainLV[c]));
            memWrite(5'(2 * c + 1), 8'(gainRV[c]));
        end
        memWrite(5'h1F, {6'd0, extEnV, muteV});
    endtask

    // Apply the configuration early in a frame and let two frame boundaries pass.
    task automatic settleFrames();
        waitPh(4);
        applyStimulus();
        waitStrobe();
        waitStrobe();
        @(negedge vga_clk);
    endtask

    task automatic measureDuty(output int onesL, output int onesR);
        onesL = 0;
        onesR = 0;
        @(negedge vga_clk);
        for (int i = 0; i < DAC_WINDOW; i++) begin
            @(negedge vga_clk);
            if (AUDIOL) onesL++;
            if (AUDIOR) onesR++;
        end
    endtask

    task automatic randomConfig();
        for (int c = 0; c < NCH; c++) begin
            if ($urandom_range(0, 3) == 0) srcV[c] = int'($urandom_range(0, (2 ** IN_W) - 1)) - (2 ** (IN_W - 1));
            else srcV[c] = int'($urandom_range(0, 4000)) - 2000;
            gainLV[c] = int'($urandom_range(0, 255));
            gainRV[c] = int'($urandom_range(0, 255));
        end
        sampLV = int'($urandom_range(0, 6000)) - 3000;
        sampRV = int'($urandom_range(0, 6000)) - 3000;
        extEnV = 1'($urandom_range(0, 1));
        muteV  = 1'($urandom_range(0, 1));
    endtask

    initial begin
        logic [7:0] rd;
        int         dutyL;
        int         dutyR;
        int         expL;
        int         expR;
        int         strobeAt;

        reset       = 1'b1;
        mem_wr      = 1'b0;
        mem_rd      = 1'b0;
        mem_w_addr  = '0;
        mem_r_addr  = '0;
        mem_data_wr = '0;
        src_data    = '0;
        for (int c = 0; c < NCH; c++) begin
            srcV[c]   = 0;
            gainLV[c] = 128;
            gainRV[c] = 128;
            unityV[c] = 128;
        end
        srcV[0] = 1000;
        sampLV  = 0;
        sampRV  = 0;
        extEnV  = 1'b1;
        muteV   = 1'b0;
        driveSources();

        repeat (3) @(negedge vga_clk);
        checkOutput("reset soundcounter", longint'(soundcounter), 0);
        checkOutput("reset frame_strobe", longint'(frame_strobe), 0);
        checkOutput("reset AUDIOL", longint'(AUDIOL), 0);
        checkOutput("reset AUDIOR", longint'(AUDIOR), 0);
        checkOutput("reset mem_data_rd", longint'(mem_data_rd), 0);
        reset = 1'b0;

        memRead(BASE_ADDR, 5'h00, rd);  checkOutput("GAINL0 reset", longint'(rd), 128);
        memRead(BASE_ADDR, 5'h01, rd);  checkOutput("GAINR0 reset", longint'(rd), 128);
        memRead(BASE_ADDR, 5'h1F, rd);  checkOutput("CTRL reset", longint'(rd), 2);
        memRead(BASE_ADDR, 5'h1C, rd);  checkOutput("reserved 1C", longint'(rd), 0);
        memRead(BASE_ADDR, 5'h1E, rd);  checkOutput("STATUS reset", longint'(rd), 0);
        memRead(BASE_ADDR + 10'd1, 5'h00, rd);  checkOutput("outside window", longint'(rd), 0);
        @(negedge vga_clk);
        checkOutput("mem_rd low", longint'(mem_data_rd), 0);

        waitStrobe();
        checkOutput("first strobe cycle", longint'(soundcounter), 63);
        @(negedge vga_clk);
        checkOutput("unity lvalue", longint'($signed(dut.r_lvalue)), 1000);
        checkOutput("unity rvalue", longint'($signed(dut.r_rvalue)), 1000);
        measureDuty(dutyL, dutyR);
        checkOutput("unity AUDIOL duty", longint'(dutyL), 5096);
        checkOutput("unity AUDIOR duty", longint'(dutyR), 5096);

        gainLV[0] = 8'h40;
        gainRV[0] = 0;
        settleFrames();
        checkOutput("half gain lvalue", longint'($signed(dut.r_lvalue)), 500);
        checkOutput("zero gain rvalue", longint'($signed(dut.r_rvalue)), 0);
        measureDuty(dutyL, dutyR);
        checkOutput("half gain AUDIOL duty", longint'(dutyL), 4596);
        checkOutput("zero gain AUDIOR duty", longint'(dutyR), 4096);

        for (int c = 0; c < NCH; c++) begin
            srcV[c]   = (2 ** (IN_W - 1)) - 1;
            gainLV[c] = 255;
            gainRV[c] = 255;
        end
        settleFrames();
        checkOutput("clip lvalue", longint'($signed(dut.r_lvalue)), 4095);
        checkOutput("clip rvalue", longint'($signed(dut.r_rvalue)), 4095);
        memRead(BASE_ADDR, 5'h1E, rd);
        checkOutput("STATUS after clip", longint'(rd), 3);
        for (int c = 0; c < NCH; c++) begin
            srcV[c]   = 0;
            gainLV[c] = 128;
            gainRV[c] = 128;
        end
        settleFrames();
        memWrite(5'h1E, 8'h00);
        memRead(BASE_ADDR, 5'h1E, rd);
        checkOutput("STATUS cleared", longint'(rd), 0);

        srcV[0] = 1000;
        muteV   = 1'b1;
        settleFrames();
        checkOutput("muted lvalue", longint'($signed(dut.r_lvalue)), 1000);
        measureDuty(dutyL, dutyR);
        checkOutput("mute AUDIOL duty", longint'(dutyL), 4096);
        checkOutput("mute AUDIOR duty", longint'(dutyR), 4096);

        srcV[0] = 0;
        sampLV  = 16'h7FFF;
        sampRV  = 16'h7FFF;
        extEnV  = 1'b0;
        muteV   = 1'b0;
        settleFrames();
        checkOutput("ext disabled lvalue", longint'($signed(dut.r_lvalue)), 0);
        checkOutput("ext disabled rvalue", longint'($signed(dut.r_rvalue)), 0);

        for (int it = 0; it < 20; it++) begin
            randomConfig();
            waitPh(4);
            applyStimulus();
            waitStrobe();
            waitPh(4);
            memWrite(5'h1E, 8'h00);
            waitStrobe();
            @(negedge vga_clk);
            expL = mixModel(srcV, gainLV, extEnV ? sampLV : 0);
            expR = mixModel(srcV, gainRV, extEnV ? sampRV : 0);
            checkOutput($sformatf("random %0d lvalue", it), longint'($signed(dut.r_lvalue)), longint'(clampModel(expL)));
            checkOutput($sformatf("random %0d rvalue", it), longint'($signed(dut.r_rvalue)), longint'(clampModel(expR)));
            memRead(BASE_ADDR, 5'h1E, rd);
            checkOutput($sformatf("random %0d STATUS", it), longint'(rd),
                        longint'({(clampModel(expR) != expR), (clampModel(expL) != expL)}));
        end

        waitPh(20);
        reset = 1'b1;
        #1;
        checkOutput("midframe reset soundcounter", longint'(soundcounter), 0);
        checkOutput("midframe reset AUDIOL", longint'(AUDIOL), 0);
        checkOutput("midframe reset AUDIOR", longint'(AUDIOR), 0);
        checkOutput("midframe reset lvalue", longint'($signed(dut.r_lvalue)), 0);
        repeat (3) @(negedge vga_clk);
        reset    = 1'b0;
        strobeAt = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge vga_clk);
            #1;
            if (frame_strobe) begin
                strobeAt = i;
                break;
            end
        end
        checkOutput("strobe after reset", longint'(strobeAt), 63);
        repeat (2) @(negedge vga_clk);
        checkOutput("first frame after reset", longint'($signed(dut.r_lvalue)),
                    longint'(clampModel(mixModel(srcV, unityV, 0))));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
